// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and the core's control unit.
package data_mem_responder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3_LEN = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [F3_LEN-1:0] F3_B  = 3'b000;
  localparam logic [F3_LEN-1:0] F3_H  = 3'b001;
  localparam logic [F3_LEN-1:0] F3_W  = 3'b010;
  localparam logic [F3_LEN-1:0] F3_BU = 3'b100;
  localparam logic [F3_LEN-1:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Request context still needed after accept (address and data live in the SRAM port registers).
  typedef struct packed {
    logic              we;
    logic [F3_LEN-1:0] funct3;
    logic [1:0]        off;
  } req_ctx_t;

  function automatic logic is_mem_opcode(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

  // Illegal width/sign code for the direction, or an address not aligned to the access size.
  function automatic logic access_err(input logic we, input logic [F3_LEN-1:0] funct3,
                                      input logic [1:0] off);
    logic legal;
    logic misaligned;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; misaligned = off[0]; end
      F3_W:  begin legal = 1'b1; misaligned = |off; end
      F3_BU: legal = ~we;
      F3_HU: begin legal = ~we; misaligned = off[0]; end
      default: legal = 1'b0;
    endcase
    return ~legal | misaligned;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering: store byte enables and replication, load shift and extension.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [F3_LEN-1:0] funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [15:0] lane;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (funct3)
      F3_B: begin
        be        = 4'(4'b0001 << off);
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        be        = 4'(4'b0011 << {off[1], 1'b0});
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Only the low half-word of the shifted word is ever needed for sub-word loads.
  assign lane = 16'(rdata >> {off, 3'b000});

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
      F3_BU: rdata_ext = {24'd0, lane[7:0]};
      F3_H:  rdata_ext = {{16{lane[15]}}, lane[15:0]};
      F3_HU: rdata_ext = {16'd0, lane[15:0]};
      F3_W:  rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time onto a word-wide synchronous SRAM port,
// returning extended load data or a store completion with an error flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned CHECK_RANGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state, state_next;
  req_ctx_t          ctx, ctx_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;
  logic              mem_en_d;
  logic [3:0]        mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  logic              out_of_range;
  logic              req_err;
  logic [2:0]        align_funct3;
  logic [1:0]        align_off;
  logic [3:0]        align_be;
  logic [31:0]       align_wdata;
  logic [31:0]       align_rdata;

  if (CHECK_RANGE != 0 && ADDR_W < 30) begin : g_range
    assign out_of_range = |req_addr[31:ADDR_W+2];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign req_err = access_err(req_we, req_funct3, req_addr[1:0]) | out_of_range;
  assign stall   = req_valid & ~rsp_valid;

  // Steer the live request while idle, the captured context while the load is in flight.
  assign align_funct3 = (state == S_IDLE) ? req_funct3    : ctx.funct3;
  assign align_off    = (state == S_IDLE) ? req_addr[1:0] : ctx.off;

  mem_lane_align u_align (
    .funct3    (align_funct3),
    .off       (align_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (align_be),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_valid) state_next = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: state_next = ctx.we ? S_RESP : S_WAIT;
      S_WAIT:   if (cnt == CNT_W'(1)) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Next values of every registered output, context and wait counter.
  always_comb begin
    req_ready_d = (state_next == S_IDLE);
    rsp_valid_d = (state_next == S_RESP);
    mem_en_d    = (state_next == S_ACCESS);
    rsp_err_d   = 1'b0;
    mem_be_d    = 4'b0000;
    rsp_rdata_d = rsp_rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    ctx_d       = ctx;
    cnt_d       = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          ctx_d = '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (req_we) begin
              mem_be_d    = align_be;
              mem_wdata_d = align_wdata;
            end
          end
        end
      end
      S_ACCESS: begin
        cnt_d = CNT_W'(READ_LAT);
        if (ctx.we) rsp_rdata_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) rsp_rdata_d = align_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ctx       <= '0;
      cnt       <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      mem_en    <= mem_en_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      ctx       <= ctx_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder for the load/store requests the core issues when MemRead or MemWrite is decoded.
- Takes one request at a time from the execute/memory stage and drives a word-wide synchronous SRAM port with byte enables.
- Returns aligned, sign- or zero-extended load data, or a store completion, with an error flag.
- Holds the core stalled while the access is in flight.

Parameters:
- ADDR_W, 10, SRAM word-address width (memory = 2^ADDR_W words of 32 bits).
- READ_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
- CHECK_RANGE, 1, when 1, byte addresses at or beyond 4*2^ADDR_W flag an error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request; held stable until rsp_valid.
- req_ready  out  1  responder can accept a request (state IDLE).
- req_we  in  1  1 = store (MemWrite), 0 = load (MemRead).
- req_funct3  in  3  RV32I width/sign code from the instruction funct3 field.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3 or out-of-range; valid with rsp_valid.
- stall  out  1  combinational: req_valid & ~rsp_valid.
- mem_en  out  1  SRAM access strobe, one cycle per access.
- mem_be  out  4  byte write enables; 0000 on reads.
- mem_addr  out  ADDR_W  word address, req_addr[ADDR_W+1:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  SRAM read data, valid READ_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, mid-operation included):
  - state = IDLE; req_ready = 1.
  - rsp_valid, rsp_err, mem_en = 0; mem_be = 0000; rsp_rdata, mem_addr, mem_wdata = 0.
  - An in-flight access is abandoned. No write strobe is issued after reset asserts.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Accept when req_valid = 1; capture all req_* fields into registers.
  - Any error -> RESP with rsp_err = 1; no SRAM access is made.
  - Otherwise -> ACCESS.
- Error conditions:
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
  - Half-word access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
  - CHECK_RANGE = 1 and req_addr[31:ADDR_W+2] != 0.
- ACCESS (one cycle):
  - mem_en = 1.
  - Store: mem_be set as below -> RESP.
  - Load: mem_be = 0000; counter = READ_LAT -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Sample mem_rdata at the end of cycle ACCESS + READ_LAT, then -> RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle -> IDLE.
  - rsp_rdata holds until the next response.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << {addr[1], 0}; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111; wdata = wdata.
- Load extraction:
  - lane = mem_rdata >> (8 * addr[1:0]).
  - 000: sign-extend lane[7:0]; 100: zero-extend lane[7:0].
  - 001: sign-extend lane[15:0]; 101: zero-extend lane[15:0].
  - 010: full word.
- Latency, accept cycle = T0:
  - Store: rsp_valid at T2.
  - Load: rsp_valid at T2 + READ_LAT.
  - Error: rsp_valid at T1.
- Back-to-back: req_ready is low in ACCESS, WAIT and RESP. The next request is accepted in IDLE, the cycle after RESP, so there is 1 idle cycle minimum between accepts.
- req_valid dropping mid-access is a protocol violation. The access still completes and rsp_valid still pulses.

Decomposition:
- Shared package:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - Opcode constants Load/Store, shared with the control unit.
- Sub-module: mem_lane_align. Combinational; handles byte-enable/replication for stores and shift/extend for loads. Unit-testable alone.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> T1 mem_en=1, mem_be=1111, mem_addr=4; T2 rsp_valid=1, rsp_err=0.
- LB addr 0x13, mem word 0x80AA55CC (READ_LAT=1) -> rsp_rdata=0xFFFFFF80 at T3. LBU same address -> 0x00000080.
- SB addr 0x06, wdata 0x000000AB -> mem_be=0100, mem_wdata=0xABABABAB. SH addr 0x06 -> mem_be=1100.
- LW addr 0x02 -> rsp_valid at T1, rsp_err=1, mem_en never asserted. Load funct3=011 -> same error response.
- CHECK_RANGE=1, ADDR_W=10, LW addr 0x1000 -> rsp_err=1. LH addr 0xFFE -> normal access, mem_addr=0x3FF.
- rst_n low during WAIT of a load -> outputs return to reset values immediately. After release, a new SW completes normally with no stale rsp_valid.
